// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned STAT_W = 16;

    // Arbiter states kept as plain constants for legacy tools
    typedef logic [0:0] state_t;
    localparam state_t ST_ARB  = 1'b0;
    localparam state_t ST_LOCK = 1'b1;

    // Owner of the read currently in flight
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_UART = 2'd2
    } owner_e;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// UART starvation counter: counts denied cycles, saturates, flags forced win.
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic uart_req,
    input  logic uart_gnt,
    output logic force_c
);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    assign force_c = (wait_cnt_q == CNT_W'(MAX_WAIT));

    // Next count: clear on grant or idle, else saturating increment
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!uart_req || uart_gnt) begin
            wait_cnt_d = '0;
        end else if (!force_c) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester (CPU / UART) arbiter for the single-port data memory.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          uart_req,
    input  logic          uart_we,
    input  logic          uart_lock,
    input  logic [AW-1:0] uart_addr,
    input  logic [DW-1:0] uart_wdata,
    output logic          uart_gnt,
    output logic          uart_rvalid,
    output logic [DW-1:0] uart_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] cpu_stall_cnt,
    output logic [STAT_W-1:0] uart_force_cnt
`endif
);

    state_t        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [DW-1:0] cpu_rdata_q, uart_rdata_q;
    logic          cpu_req_v, uart_req_v;
    logic          cpu_win, uart_win;
    logic          force_c;

    // Requests are masked while reset is held so all outputs read zero
    assign cpu_req_v  = cpu_req  & ~reset;
    assign uart_req_v = uart_req & ~reset;

    dmem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .uart_req (uart_req_v),
        .uart_gnt (uart_win),
        .force_c  (force_c)
    );

    // Winner selection: LOCK serves only the UART; ARB is CPU-first unless starved
    always_comb begin
        cpu_win  = 1'b0;
        uart_win = 1'b0;
        if (state_q == ST_LOCK) begin
            uart_win = uart_req_v;
        end else if (uart_req_v && force_c) begin
            uart_win = 1'b1;
        end else if (cpu_req_v) begin
            cpu_win = 1'b1;
        end else if (uart_req_v) begin
            uart_win = 1'b1;
        end
    end

    // Zero-latency memory command from the winner
    always_comb begin
        mem_en    = cpu_win | uart_win;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_win) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (uart_win) begin
            mem_we    = uart_we;
            mem_addr  = uart_addr;
            mem_wdata = uart_wdata;
        end
    end

    assign uart_gnt  = uart_win;
    assign cpu_stall = cpu_req_v & ~cpu_win;

    // Next state and read ownership
    always_comb begin
        state_d = state_q;
        owner_d = OWN_NONE;
        case (state_q)
            ST_ARB:  if (uart_win && uart_lock) state_d = ST_LOCK;
            ST_LOCK: if (!uart_lock && (!uart_req_v || uart_win)) state_d = ST_ARB;
            default: state_d = ST_ARB;
        endcase
        if (cpu_win && !cpu_we) begin
            owner_d = OWN_CPU;
        end else if (uart_win && !uart_we) begin
            owner_d = OWN_UART;
        end
    end

    // State, owner and held read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_ARB;
            owner_q      <= OWN_NONE;
            cpu_rdata_q  <= '0;
            uart_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (owner_q == OWN_CPU)  cpu_rdata_q  <= mem_rdata;
            if (owner_q == OWN_UART) uart_rdata_q <= mem_rdata;
        end
    end

    // Return data is visible in the rvalid cycle, then held by the register
    assign cpu_rvalid  = (owner_q == OWN_CPU);
    assign uart_rvalid = (owner_q == OWN_UART);
    assign cpu_rdata   = cpu_rvalid  ? mem_rdata : cpu_rdata_q;
    assign uart_rdata  = uart_rvalid ? mem_rdata : uart_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] cpu_stall_cnt_q, uart_force_cnt_q;

    // Saturating statistics counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_stall_cnt_q  <= '0;
            uart_force_cnt_q <= '0;
        end else begin
            if (cpu_stall && (cpu_stall_cnt_q != '1)) begin
                cpu_stall_cnt_q <= cpu_stall_cnt_q + STAT_W'(1);
            end
            if (uart_win && force_c && (state_q == ST_ARB) && (uart_force_cnt_q != '1)) begin
                uart_force_cnt_q <= uart_force_cnt_q + STAT_W'(1);
            end
        end
    end

    assign cpu_stall_cnt  = cpu_stall_cnt_q;
    assign uart_force_cnt = uart_force_cnt_q;
`endif

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port, 16-bit synchronous data memory between two requesters: the CPU MEM stage and the UART loader/debug bridge.
- The CPU has priority by default. A starvation counter guarantees the UART a slot, and a lock mode gives the UART uninterrupted bursts.
- Issues `cpu_stall` to the pipeline stall/flush logic whenever a CPU access is held off.
- Read data returns one cycle after issue and is routed back to the owner of that access.

Parameters:
- AW, 8, data-memory word-address width
- DW, 16, data width
- MAX_WAIT, 4, cycles a pending UART request may be denied before it is forced to win (range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU MEM-stage access request, level
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU store data
- cpu_stall  out  1  CPU request pending but not granted this cycle
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DW  load data to the CPU
- uart_req  in  1  UART access request, held until uart_gnt
- uart_we  in  1  1=write, 0=read
- uart_lock  in  1  request burst ownership
- uart_addr  in  AW  UART word address
- uart_wdata  in  DW  UART write data
- uart_gnt  out  1  UART access issued this cycle
- uart_rvalid  out  1  one-cycle pulse: uart_rdata valid
- uart_rdata  out  DW  read data to the UART
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en with !mem_we

Behaviour:
- **Reset** (async, reset=1):
  - state=ARB, wait_cnt=0, rd_owner=NONE.
  - All outputs 0; cpu_rdata and uart_rdata = 0.
- **State ARB**, winner selected combinationally each cycle:
  - uart_req && wait_cnt==MAX_WAIT → UART wins.
  - else cpu_req → CPU wins.
  - else uart_req → UART wins.
  - else idle: mem_en=0.
- **State LOCK**:
  - Only the UART is granted; a CPU request always stalls.
  - LOCK is exited when uart_lock=0 on a cycle where uart_req=0 or a grant occurs.
  - On exit, the next state is ARB.
- **ARB→LOCK transition**: uart_gnt && uart_lock; takes effect from the next cycle.
- **Memory interface**:
  - mem_en, mem_we, mem_addr and mem_wdata are driven combinationally from the winner. Zero-cycle issue latency.
  - mem_addr and mem_wdata = 0 when idle.
- **Grant and stall**:
  - uart_gnt = UART wins.
  - cpu_stall = cpu_req && !CPU wins.
- **wait_cnt**:
  - Increments (saturating at MAX_WAIT) on cycles with uart_req && !uart_gnt.
  - Clears on uart_gnt or when uart_req=0.
- **Read return**:
  - A read issued in cycle N sets rd_owner (registered) to CPU or UART.
  - In cycle N+1 the owner's rvalid pulses, and its rdata register captures mem_rdata. The rdata register holds its value until the next read for that owner.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating owners return in issue order, one per cycle.
- **Simultaneous first requests**: the CPU wins; the UART waits and wait_cnt=1 after that cycle.
- **Reset mid-operation**:
  - A pending rvalid is dropped.
  - LOCK is abandoned.
  - Requesters must reissue.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- When defined, adds two saturating 16-bit counters:
  - cpu_stall_cnt: counts cycles with cpu_stall=1.
  - uart_force_cnt: counts grants won by starvation override.
- Each counter is exported on its own output port of the same name, and both are cleared by reset.
- When undefined, the ports and logic are absent. All other behaviour is identical.

Decomposition:
- A shared package dmem_arb_pkg holds:
  - the state enum {ARB, LOCK}
  - the owner enum {NONE, CPU, UART}
  - the default widths AW=8, DW=16
- One natural sub-module: dmem_arb_starve_cnt, the wait counter with its saturate/clear logic and force output.

Test Plan:
- **CPU-only load**: cpu_req=1, we=0, addr=0x12, memory holds 0xBEEF → mem_en=1 in the same cycle, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=0xBEEF.
- **Simultaneous requests**: cpu and uart reads, MAX_WAIT=4, cpu_req held high → CPU granted cycles 0-3; uart_gnt in cycle 4 with cpu_stall=1 in that cycle; wait_cnt clears to 0.
- **Lock burst**: uart writes 0x0001..0x0003 to addrs 0x20-0x22 with uart_lock=1 while cpu_req=1 → cpu_stall=1 through the last UART grant; the CPU is granted the first cycle after lock drops.
- **Alternating reads**: CPU read addr 0x05 in cycle N, UART read addr 0x06 in cycle N+1 → cpu_rvalid at N+1 and uart_rvalid at N+2, each with correct data; no cross-delivery.
- **Write then read**: UART writes 0xA5A5 to 0x30, then the CPU reads 0x30 → cpu_rdata=0xA5A5, no rvalid on the write.
- **Async reset**: assert reset in the cycle after a read issue → no rvalid, all outputs 0 immediately, state=ARB after release.
